// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper
// Description : Drives every input combination of an N_IN-input gate in
//               ascending order. It samples the gate after a settle time and
//               checks the assembled truth table against EXPECTED.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper #(
  parameter int                  N_IN          = 3,
  parameter int                  SETTLE_CYCLES = 4,
  parameter logic [2**N_IN-1:0]  EXPECTED      = 'h3F
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic [N_IN-1:0]     in_vec,
  input  logic                gate_out,
  output logic                busy,
  output logic                done,
  output logic [2**N_IN-1:0]  tt,
  output logic                tt_valid,
  output logic                match
);

  localparam int                  c_tt_w     = 2**N_IN;
  localparam int                  c_cnt_w    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0]     c_idx_last = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              r_state;
  logic [N_IN-1:0]     r_idx;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [N_IN-1:0]     w_tt_pos;
  logic [N_IN-1:0]     w_idx_next;

  // Combination 0 lands in the MSB, so the bit position TT_W-1-idx is ~idx.
  assign w_tt_pos   = ~r_idx;
  assign w_idx_next = r_idx + N_IN'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_cnt    <= '0;
      in_vec   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tt       <= '0;
      tt_valid <= 1'b0;
      match    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_SETTLE;
            r_idx    <= '0;
            r_cnt    <= '0;
            in_vec   <= '0;
            busy     <= 1'b1;
            tt       <= '0;
            tt_valid <= 1'b0;
            match    <= 1'b0;
          end
        end

        S_SETTLE, S_SAMPLE: begin
          if (abort) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_cnt    <= '0;
            in_vec   <= '0;
            busy     <= 1'b0;
            tt       <= '0;
            tt_valid <= 1'b0;
            match    <= 1'b0;
          end else if (r_state == S_SETTLE) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
            if (r_cnt == c_cnt_last) begin
              r_state <= S_SAMPLE;
            end
          end else begin
            tt[w_tt_pos] <= gate_out;
            if (r_idx == c_idx_last) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= w_idx_next;
              r_cnt   <= '0;
              in_vec  <= w_idx_next;
              r_state <= S_SETTLE;
            end
          end
        end

        S_DONE: begin
          done     <= 1'b1;
          tt_valid <= 1'b1;
          match    <= (tt == EXPECTED);
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_sweeper
// Description : Directed sweeps with a queued scoreboard of expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, abort_a = 1'b0;
  logic       start_b = 1'b0, abort_b = 1'b0;
  logic       gate_sel = 1'b0;
  logic       gate_a, gate_b_dly = 1'b0;
  logic [2:0] in_vec_a, in_vec_b;
  logic [7:0] tt_a, tt_b;
  logic       busy_a, done_a, tt_valid_a, match_a;
  logic       busy_b, done_b, tt_valid_b, match_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] tt;
    logic       m;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  // Gate under test: either {in1,in2,in3} >= 2 (0x3F) or AND3 (0x01).
  assign gate_a = gate_sel ? (&in_vec_a) : (in_vec_a >= 3'd2);
  always @(posedge clk) gate_b_dly <= (in_vec_b >= 3'd2);

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(4), .EXPECTED(8'h3F)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .in_vec(in_vec_a), .gate_out(gate_a), .busy(busy_a), .done(done_a),
    .tt(tt_a), .tt_valid(tt_valid_a), .match(match_a)
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(1), .EXPECTED(8'h3F)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .in_vec(in_vec_b), .gate_out(gate_b_dly), .busy(busy_b), .done(done_b),
    .tt(tt_b), .tt_valid(tt_valid_b), .match(match_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_in(input int k);
    return (k >= 40) ? 3'd7 : 3'(k / 5);
  endfunction

  task automatic sweep_a(input int abort_at, input int reset_at, input bit extra_starts,
                         input logic [7:0] exp_tt);
    int  done_cnt = 0;
    int  done_edge = -1;
    bit  step_ok = 1'b1;
    int  limit;
    bit  normal;
    normal = (abort_at == 0) && (reset_at == 0);
    limit  = (abort_at != 0) ? abort_at - 1 : (reset_at != 0) ? reset_at - 1 : 40;
    @(negedge clk);
    start_a = 1'b1;
    if (normal) q_a.push_back('{tt: exp_tt, m: (exp_tt == 8'h3F)});
    @(posedge clk); #1;
    chk("a_busy_after_start", {31'd0, busy_a}, 1);
    chk("a_tt_cleared_at_start", {24'd0, tt_a}, 0);
    chk("a_tt_valid_cleared_at_start", {31'd0, tt_valid_a}, 0);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start_a = extra_starts && (k == 3 || k == 20);
      abort_a = (k == abort_at);
      @(posedge clk);
      if (k == reset_at) begin
        #2 rst_n = 1'b0;
        #1 chk("a_async_reset_outputs",
               {18'd0, in_vec_a, busy_a, done_a, tt_a, tt_valid_a, match_a}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        #1;
      end
      if (done_a) begin
        done_cnt++;
        if (done_edge < 0) done_edge = k;
      end
      if (k <= limit && in_vec_a !== exp_in(k)) step_ok = 1'b0;
      if (k == abort_at) begin
        chk("a_abort_clears",
            {26'd0, in_vec_a, busy_a, tt_a != 8'd0, tt_valid_a, match_a}, 0);
      end
    end
    start_a = 1'b0;
    abort_a = 1'b0;
    chk("a_in_vec_stepping", {31'd0, step_ok}, 1);
    if (normal) begin
      chk("a_done_edge", done_edge, 41);
      chk("a_done_count", done_cnt, 1);
      chk("a_in_vec_hold", {29'd0, in_vec_a}, 7);
      chk("a_busy_after_done", {31'd0, busy_a}, 0);
    end else begin
      chk("a_no_done_when_cut", done_cnt, 0);
    end
  endtask

  task automatic sweep_b();
    int done_edge = -1;
    @(negedge clk);
    start_b = 1'b1;
    q_b.push_back('{tt: 8'h3F, m: 1'b1});
    @(posedge clk); #1;
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      @(posedge clk); #1;
      if (done_b && done_edge < 0) done_edge = k;
    end
    chk("b_done_edge", done_edge, 17);
  endtask

  initial begin
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (done_a) begin
            chk("a_done_expected", {31'd0, q_a.size() != 0}, 1);
            if (q_a.size() != 0) begin
              e = q_a.pop_front();
              chk("a_tt", {24'd0, tt_a}, {24'd0, e.tt});
              chk("a_match", {31'd0, match_a}, {31'd0, e.m});
              chk("a_tt_valid", {31'd0, tt_valid_a}, 1);
            end
          end
          if (done_b) begin
            chk("b_done_expected", {31'd0, q_b.size() != 0}, 1);
            if (q_b.size() != 0) begin
              e = q_b.pop_front();
              chk("b_tt", {24'd0, tt_b}, {24'd0, e.tt});
              chk("b_match", {31'd0, match_b}, {31'd0, e.m});
            end
          end
        end
      end
      begin : stimulus
        repeat (2) @(negedge clk);
        chk("a_reset_state", {18'd0, in_vec_a, busy_a, done_a, tt_a, tt_valid_a, match_a}, 0);
        chk("b_reset_state", {18'd0, in_vec_b, busy_b, done_b, tt_b, tt_valid_b, match_b}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        gate_sel = 1'b0;
        sweep_a(0, 0, 1'b0, 8'h3F);
        gate_sel = 1'b1;
        sweep_a(0, 0, 1'b0, 8'h01);
        gate_sel = 1'b0;
        sweep_a(0, 0, 1'b1, 8'h3F);

        // Abort while idle must leave the previous result intact.
        @(negedge clk);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk("a_idle_abort_keeps_tt", {24'd0, tt_a}, 32'h3F);
        chk("a_idle_abort_keeps_valid", {30'd0, tt_valid_a, match_a}, 3);

        sweep_a(17, 0, 1'b0, 8'h3F);
        sweep_a(0, 0, 1'b0, 8'h3F);
        sweep_a(0, 25, 1'b0, 8'h3F);
        sweep_a(0, 0, 1'b0, 8'h3F);

        sweep_b();
        repeat (3) @(negedge clk);
        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);
      end
    join_any
    disable fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
